// File: rtl/prio_pkg.sv
// Shared definitions for the registered priority / round-robin arbiter.
// Holds the selection-mode constants, the FSM state type and the index-width helper.
package prio_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // Keeps the index at least one bit wide when N is very small.
    function automatic int idxWidth(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational winner selection over a request vector.
// Supports two modes: fixed priority (highest index wins) and round-robin (first set bit at or above ptr, wrapping).
module prio_pick
    import prio_pkg::*;
#(
    parameter int N = 16,
    localparam int IDX_W = idxWidth(N)
) (
    input  logic [N-1:0]     vec_i,
    input  logic [IDX_W-1:0] ptr_i,
    input  logic             mode_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             found_o
);

    localparam int PW = IDX_W + 1;

    logic [IDX_W-1:0] fixIdx;
    logic [IDX_W-1:0] rrIdx;
    logic [N-1:0]     hiMask;
    logic [2*N-1:0]   dblVec;
    logic [PW-1:0]    rrPos;

    // The lower copy keeps only bits at or above ptr, so the lowest set bit
    // of the doubled vector is the wrapped round-robin winner.
    always_comb begin
        fixIdx = '0;
        for (int i = 0; i < N; i++) begin
            if (vec_i[i]) begin
                fixIdx = IDX_W'(i);
            end
        end

        hiMask = '0;
        for (int i = 0; i < N; i++) begin
            if (i >= int'(ptr_i)) begin
                hiMask[i] = 1'b1;
            end
        end

        dblVec = {vec_i, vec_i & hiMask};
        rrPos  = '0;
        for (int i = 2*N-1; i >= 0; i--) begin
            if (dblVec[i]) begin
                rrPos = PW'(i);
            end
        end

        rrIdx   = (rrPos >= PW'(N)) ? IDX_W'(rrPos - PW'(N)) : IDX_W'(rrPos);
        found_o = |vec_i;
        idx_o   = (mode_i == MODE_RR) ? rrIdx : fixIdx;
    end

endmodule

// File: rtl/prio_arbiter_rr.sv
// Registered arbiter: sticky pending requests, one held grant on a valid/ready handshake.
// The winner is cleared from pending on accept unless it is re-requested in that same cycle.
module prio_arbiter_rr
    import prio_pkg::*;
#(
    parameter int N       = 16,
    parameter int PTR_RST = 0,
    localparam int IDX_W  = idxWidth(N)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             ena_i,
    input  logic [N-1:0]     req_i,
    input  logic             rr_mode_i,
    input  logic             grant_ready_i,
    output logic             grant_valid_o,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic [N-1:0]     pending_o,
    output logic             none_o
);

    state_e           state_q,      state_d;
    logic [N-1:0]     pending_q,    pending_d;
    logic             grantValid_q, grantValid_d;
    logic [IDX_W-1:0] grantIdx_q,   grantIdx_d;
    logic [IDX_W-1:0] ptr_q,        ptr_d;
    logic             grantMode_q,  grantMode_d;
    logic             none_q,       none_d;

    logic [IDX_W-1:0] pickIdx;
    logic             pickFound;
    logic             accept;
    logic [N-1:0]     clrMask;

    prio_pick #(
        .N (N)
    ) u_pick (
        .vec_i   (pending_q),
        .ptr_i   (ptr_q),
        .mode_i  (rr_mode_i),
        .idx_o   (pickIdx),
        .found_o (pickFound)
    );

    // The mode is latched with the grant so a change during GRANT cannot
    // affect how the pointer advances on accept.
    always_comb begin
        state_d      = state_q;
        grantValid_d = grantValid_q;
        grantIdx_d   = grantIdx_q;
        ptr_d        = ptr_q;
        grantMode_d  = grantMode_q;

        accept    = (state_q == GRANT) && grantValid_q && grant_ready_i;
        clrMask   = accept ? (N'(1) << grantIdx_q) : '0;
        pending_d = (pending_q & ~clrMask) | req_i;

        case (state_q)
            IDLE: begin
                if (pickFound) begin
                    grantIdx_d   = pickIdx;
                    grantValid_d = 1'b1;
                    grantMode_d  = rr_mode_i;
                    state_d      = GRANT;
                end
            end
            GRANT: begin
                if (accept) begin
                    grantValid_d = 1'b0;
                    state_d      = IDLE;
                    if (grantMode_q == MODE_RR) begin
                        ptr_d = (grantIdx_q == IDX_W'(N-1)) ? '0 : grantIdx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        none_d = (pending_d == '0) && !grantValid_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            pending_q    <= '0;
            grantValid_q <= 1'b0;
            grantIdx_q   <= '0;
            ptr_q        <= IDX_W'(PTR_RST);
            grantMode_q  <= MODE_FIXED;
            none_q       <= 1'b1;
        end else if (ena_i) begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            grantValid_q <= grantValid_d;
            grantIdx_q   <= grantIdx_d;
            ptr_q        <= ptr_d;
            grantMode_q  <= grantMode_d;
            none_q       <= none_d;
        end
    end

    assign grant_valid_o = grantValid_q;
    assign grant_idx_o   = grantIdx_q;
    assign pending_o     = pending_q;
    assign none_o        = none_q;

endmodule
